mc_controller: RTL
==================

# mc_controller

Multicycle main controller for the MIPS core: a Moore-style FSM that sequences the shared-memory multicycle datapath through fetch, decode, execute, memory and writeback for every supported opcode, including SB, BLE and LI. It sits beside the ALU decoder and drives every datapath enable and mux select. It also stretches memory states with a ready handshake so the single instruction/data memory can insert wait states.

## Interface
Parameters: none.
- `clk` in 1: core clock, rising edge
- `reset` in 1: synchronous, active-high
- `op` in 6: opcode from instruction register, stable from DECODE onward
- `mem_ready` in 1: memory completes the current access this cycle
- `pcwrite, irwrite, regwrite, memwrite` out 1: write enables
- `iord, alusrca, regdst, memtoreg` out 1: mux selects
- `alusrcb, pcsrc, aluop` out 2: mux selects / ALU decoder class
- `branch` out 1: conditional PC update this cycle (datapath gates with its compare)
- `bltype` out 1: 0 = BEQ compare, 1 = BLE compare
- `memwidth` out 1: 1 = word store, 0 = byte store
- `illegal` out 1: illegal opcode trapped (macro only, else tied 0)
- `state` out 4: current state encoding, for debug and bench

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, IMMWB=10, JEX=11, BLEEX=12, LIEX=13, HALT=14.
- Any output not listed for a state is 0; `memwidth` is 1 except in MEMWR with SB.
- FETCH: alusrcb=01; irwrite=pcwrite=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: alusrcb=11. Next state by op:
  - 100011/101011/101000 -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 -> BEQEX
  - 011111 -> BLEEX
  - 001000 -> ADDIEX
  - 010001 -> LIEX
  - 000010 -> JEX
  - other -> illegal handling (see Configuration)
- MEMADR: alusrca=1, alusrcb=10. Next state: LW -> MEMRD; SW/SB -> MEMWR.
- MEMRD: iord=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: memtoreg=1, regwrite=1. Next state FETCH.
- MEMWR: iord=1, memwrite=1, memwidth = (op==101011). Holds, with memwrite kept asserted, until mem_ready=1, then goes to FETCH.
- RTYPEEX: alusrca=1, aluop=10. Next state RTYPEWB.
- RTYPEWB: regdst=1, regwrite=1. Next state FETCH.
- BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1, bltype=0. Next state FETCH.
- BLEEX: same as BEQEX except bltype=1. Next state FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next state IMMWB.
- LIEX: alusrca=1, alusrcb=10, aluop=11. Next state IMMWB.
- IMMWB: regwrite=1. Next state FETCH.
- JEX: pcsrc=10, pcwrite=1. Next state FETCH.

## Timing
- Reset: while `reset`=1, every write enable is forced to 0 combinationally. The state register loads FETCH on the edge, so `state` reads 0 the cycle after.
- Reset asserted mid-instruction aborts it; no write is issued in the reset cycle.
- Cycle counts with mem_ready tied 1:
  - LW: 5
  - SW, SB, RTYPE, ADDI, LI: 4
  - BEQ, BLE, J: 3
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_ready is ignored in all other states.
- Outputs are functions of `state` (plus op for memwidth, mem_ready for FETCH enables); there is no output register.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined:
  - Illegal op in DECODE -> HALT.
  - HALT asserts illegal=1 with all enables 0.
  - HALT is left only by reset.
- `MC_ILLEGAL_TRAP_EN` undefined:
  - Illegal op in DECODE -> FETCH, so the instruction executes as a 2-cycle NOP.
  - illegal is held 0 and HALT is unreachable.

## Test plan
- Reset for 2 cycles, then release with mem_ready=1 and op=100011 -> states 0,1,2,3,4,0; regwrite=1 only in state 4; memtoreg=1 there.
- op=101000 with mem_ready low for 3 cycles in MEMWR -> MEMWR held 4 cycles with memwrite=1 and memwidth=0 throughout, then FETCH. Repeat with op=101011 -> memwidth=1.
- op=011111 -> BLEEX for 1 cycle with branch=1, bltype=1, pcsrc=01, aluop=01; op=000100 -> same outputs but bltype=0.
- op=010001 -> LIEX with aluop=11, alusrcb=10, then IMMWB with regwrite=1, regdst=0. mem_ready low 2 cycles in FETCH -> irwrite stays 0 until ready; instruction totals 6 cycles.
- Assert reset while in MEMWR -> memwrite=0 in that cycle; state=0 next cycle.
- op=111111: with the macro defined -> state=14 and illegal=1 until reset; without it -> DECODE then FETCH, no write enables asserted.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap illegal opcodes in a HALT state.
module mc_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       memwrite,
   output logic       iord,
   output logic       alusrca,
   output logic       regdst,
   output logic       memtoreg,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [1:0] aluop,
   output logic       branch,
   output logic       bltype,
   output logic       memwidth,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      IMMWB   = 4'd10,
      JEX     = 4'd11,
      BLEEX   = 4'd12,
      LIEX    = 4'd13,
      HALT    = 4'd14
   } state_t;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BLE   = 6'b011111;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LI    = 6'b010001;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t cur;

   logic pcwrite_raw;
   logic irwrite_raw;
   logic regwrite_raw;
   logic memwrite_raw;

   always_ff @(posedge clk) begin
      if (reset) begin
         cur <= FETCH;
      end else begin
         case (cur)
            FETCH:   cur <= mem_ready ? DECODE : FETCH;
            DECODE: begin
               case (op)
                  OP_LW, OP_SW, OP_SB: cur <= MEMADR;
                  OP_RTYPE:            cur <= RTYPEEX;
                  OP_BEQ:              cur <= BEQEX;
                  OP_BLE:              cur <= BLEEX;
                  OP_ADDI:             cur <= ADDIEX;
                  OP_LI:               cur <= LIEX;
                  OP_J:                cur <= JEX;
`ifdef MC_ILLEGAL_TRAP_EN
                  default:             cur <= HALT;
`else
                  default:             cur <= FETCH;
`endif
               endcase
            end
            MEMADR:  cur <= (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   cur <= mem_ready ? MEMWB : MEMRD;
            MEMWB:   cur <= FETCH;
            MEMWR:   cur <= mem_ready ? FETCH : MEMWR;
            RTYPEEX: cur <= RTYPEWB;
            RTYPEWB: cur <= FETCH;
            BEQEX:   cur <= FETCH;
            BLEEX:   cur <= FETCH;
            ADDIEX:  cur <= IMMWB;
            LIEX:    cur <= IMMWB;
            IMMWB:   cur <= FETCH;
            JEX:     cur <= FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
            HALT:    cur <= HALT;
`else
            HALT:    cur <= FETCH;
`endif
            default: cur <= FETCH;
         endcase
      end
   end

   // Outputs decode straight from the state; only FETCH enables and store width look at inputs.
   always_comb begin
      pcwrite_raw  = 1'b0;
      irwrite_raw  = 1'b0;
      regwrite_raw = 1'b0;
      memwrite_raw = 1'b0;
      iord         = 1'b0;
      alusrca      = 1'b0;
      regdst       = 1'b0;
      memtoreg     = 1'b0;
      alusrcb      = 2'b00;
      pcsrc        = 2'b00;
      aluop        = 2'b00;
      branch       = 1'b0;
      bltype       = 1'b0;
      memwidth     = 1'b1;
      illegal      = 1'b0;
      case (cur)
         FETCH: begin
            alusrcb     = 2'b01;
            irwrite_raw = mem_ready;
            pcwrite_raw = mem_ready;
         end
         DECODE: alusrcb = 2'b11;
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         MEMRD: iord = 1'b1;
         MEMWB: begin
            memtoreg     = 1'b1;
            regwrite_raw = 1'b1;
         end
         MEMWR: begin
            iord         = 1'b1;
            memwrite_raw = 1'b1;
            memwidth     = (op == OP_SW);
         end
         RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         RTYPEWB: begin
            regdst       = 1'b1;
            regwrite_raw = 1'b1;
         end
         BEQEX, BLEEX: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = 1'b1;
            bltype  = (cur == BLEEX);
         end
         ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         LIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            aluop   = 2'b11;
         end
         IMMWB: regwrite_raw = 1'b1;
         JEX: begin
            pcsrc       = 2'b10;
            pcwrite_raw = 1'b1;
         end
`ifdef MC_ILLEGAL_TRAP_EN
         HALT: illegal = 1'b1;
`endif
         default: ;
      endcase
   end

   // Reset kills writes in the same cycle so an aborted instruction cannot commit anything.
   assign pcwrite  = pcwrite_raw  & ~reset;
   assign irwrite  = irwrite_raw  & ~reset;
   assign regwrite = regwrite_raw & ~reset;
   assign memwrite = memwrite_raw & ~reset;
   assign state    = cur;

endmodule
